// File: rtl/pwm_timebase.sv
// PWM timebase: shared period counter, NUM_CH compare channels, edge- or center-aligned
// counting with double-buffered settings. Define PWM_PRESCALE_EN to add a clock prescaler.
module pwm_timebase #(
   parameter int CNT_W  = 16,
   parameter int NUM_CH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
`ifdef PWM_PRESCALE_EN
   input  logic [7:0]              prescale,
`endif
   input  logic                    mode_in,
   input  logic [CNT_W-1:0]        period_in,
   input  logic                    period_wr,
   input  logic [NUM_CH*CNT_W-1:0] cmp_in,
   input  logic                    cmp_wr,
   output logic [CNT_W-1:0]        count,
   output logic                    dir,
   output logic                    update,
   output logic [NUM_CH-1:0]       pwm_out
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef logic [NUM_CH-1:0][CNT_W-1:0] cmp_t;

   logic [CNT_W-1:0]  period_sh_q, period_act_q, period_act_d;
   cmp_t              cmp_sh_q, cmp_act_q, cmp_act_d;
   logic              mode_sh_q, mode_act_q, mode_act_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              dir_q, dir_d;
   logic              update_q, update_d;
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic              running_q, running_d;

   logic              adv;       // counter advances this clk
   logic              term;      // last cycle of the current period
   logic              boundary;  // next edge starts a new period
   logic              load;      // next edge copies shadows into active registers

   assign term     = mode_act_q ? ((count_q == '0) && dir_q) : (count_q == period_act_q);
   assign boundary = running_q && enable && adv && term;
   assign load     = !enable || (period_act_q == '0) || boundary;

`ifdef PWM_PRESCALE_EN
   logic [7:0] psc_sh_q, psc_act_q, psc_act_d, psc_cnt_q, psc_cnt_d;

   assign adv = (psc_cnt_q == psc_act_q);

   always_comb begin
      psc_act_d = load ? psc_sh_q : psc_act_q;
      psc_cnt_d = '0;
      if (running_q && enable && !adv) psc_cnt_d = psc_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_sh_q  <= '0;
         psc_act_q <= '0;
         psc_cnt_q <= '0;
      end else begin
         if (period_wr) psc_sh_q <= prescale;
         psc_act_q <= psc_act_d;
         psc_cnt_q <= psc_cnt_d;
      end
   end
`else
   assign adv = 1'b1;
`endif

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      period_act_d = load ? period_sh_q : period_act_q;
      cmp_act_d    = load ? cmp_sh_q    : cmp_act_q;
      mode_act_d   = load ? mode_sh_q   : mode_act_q;
      running_d    = enable && (period_act_d != '0);
      count_d      = '0;
      dir_d        = 1'b0;
      update_d     = 1'b0;
      pwm_d        = '0;

      if (running_d) begin
         if (!running_q) begin
            count_d = '0;
         end else if (!adv) begin
            count_d = count_q;
            dir_d   = dir_q;
         end else if (term) begin
            // A period that starts in center mode opens on count 1, so it spans exactly 2P cycles.
            count_d  = mode_sh_q ? ONE : '0;
            update_d = 1'b1;
         end else if (!mode_act_q) begin
            count_d = count_q + ONE;
         end else if (!dir_q) begin
            if (count_q == period_act_q) begin
               count_d = period_act_q - ONE;
               dir_d   = 1'b1;
            end else begin
               count_d = count_q + ONE;
            end
         end else begin
            count_d = count_q - ONE;
            dir_d   = 1'b1;
         end

         for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = (count_d < cmp_act_d[i]);
         end
      end
   end

   // NOTE: the shadow and active settings are a handful of flops, not a RAM, so they are reset like any other state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_sh_q  <= '0;
         period_act_q <= '0;
         cmp_sh_q     <= '0;
         cmp_act_q    <= '0;
         mode_sh_q    <= 1'b0;
         mode_act_q   <= 1'b0;
         count_q      <= '0;
         dir_q        <= 1'b0;
         update_q     <= 1'b0;
         pwm_q        <= '0;
         running_q    <= 1'b0;
      end else begin
         if (period_wr) period_sh_q <= period_in;
         if (cmp_wr)    cmp_sh_q    <= cmp_in;
         mode_sh_q    <= mode_in;
         period_act_q <= period_act_d;
         cmp_act_q    <= cmp_act_d;
         mode_act_q   <= mode_act_d;
         count_q      <= count_d;
         dir_q        <= dir_d;
         update_q     <= update_d;
         pwm_q        <= pwm_d;
         running_q    <= running_d;
      end
   end

   assign count   = count_q;
   assign dir     = dir_q;
   assign update  = update_q;
   assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Self-checking bench for pwm_timebase: hand-derived vector table through a scoreboard
// queue, plus mid-period reset and (when PWM_PRESCALE_EN is defined) prescaler sequences.
module tb_pwm_timebase;

   localparam int CNT_W  = 16;
   localparam int NUM_CH = 4;

   typedef struct {
      logic        en;
      logic        mode;
      logic        pwr;
      logic [15:0] per;
      logic        cwr;
      logic [63:0] cmp;
      logic [15:0] e_cnt;
      logic        e_dir;
      logic        e_upd;
      logic [3:0]  e_pwm;
   } vec_t;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    enable = 1'b0;
   logic                    mode_in = 1'b0;
   logic [CNT_W-1:0]        period_in = '0;
   logic                    period_wr = 1'b0;
   logic [NUM_CH*CNT_W-1:0] cmp_in = '0;
   logic                    cmp_wr = 1'b0;
   logic [CNT_W-1:0]        count;
   logic                    dir;
   logic                    update;
   logic [NUM_CH-1:0]       pwm_out;
`ifdef PWM_PRESCALE_EN
   logic [7:0]              prescale = '0;
`endif

   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   pwm_timebase #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
`ifdef PWM_PRESCALE_EN
      .prescale  (prescale),
`endif
      .mode_in   (mode_in),
      .period_in (period_in),
      .period_wr (period_wr),
      .cmp_in    (cmp_in),
      .cmp_wr    (cmp_wr),
      .count     (count),
      .dir       (dir),
      .update    (update),
      .pwm_out   (pwm_out)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pk(input int c0, input int c1, input int c2, input int c3);
      return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
   endfunction

   task automatic row(input logic en, input logic mode, input logic pwr, input int per,
                      input logic cwr, input logic [63:0] cmp,
                      input int cnt, input logic d, input logic u, input logic [3:0] p);
      vec_t v;
      v.en = en; v.mode = mode; v.pwr = pwr; v.per = 16'(per); v.cwr = cwr; v.cmp = cmp;
      v.e_cnt = 16'(cnt); v.e_dir = d; v.e_upd = u; v.e_pwm = p;
      vecs.push_back(v);
   endtask

   // Enabled cycle with no shadow writes.
   task automatic rn(input logic mode, input int cnt, input logic d, input logic u, input logic [3:0] p);
      row(1'b1, mode, 1'b0, 0, 1'b0, 64'h0, cnt, d, u, p);
   endtask

   task automatic stop(input logic mode);
      row(1'b0, mode, 1'b0, 0, 1'b0, 64'h0, 0, 1'b0, 1'b0, 4'b0000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] cm;

      // Edge mode, P=4, cmp = {4,5,0,2}: pwm0 on counts 0-1, pwm1 never, pwm2 always.
      cm = pk(2, 0, 5, 4);
      row(0, 0, 1, 4, 1, cm, 0, 0, 0, 4'b0000);
      stop(0);
      rn(0, 0, 0, 0, 4'b1101); rn(0, 1, 0, 0, 4'b1101); rn(0, 2, 0, 0, 4'b1100);
      rn(0, 3, 0, 0, 4'b1100); rn(0, 4, 0, 0, 4'b0100);
      rn(0, 0, 0, 1, 4'b1101); rn(0, 1, 0, 0, 4'b1101); rn(0, 2, 0, 0, 4'b1100);
      rn(0, 3, 0, 0, 4'b1100); rn(0, 4, 0, 0, 4'b0100);
      rn(0, 0, 0, 1, 4'b1101); rn(0, 1, 0, 0, 4'b1101); rn(0, 2, 0, 0, 4'b1100);
      rn(0, 3, 0, 0, 4'b1100);
      stop(0);                                     // enable dropped while count==3

      // Center mode, P=3, cmp = {1,3,0,2}.
      cm = pk(2, 0, 3, 1);
      row(0, 1, 1, 3, 1, cm, 0, 0, 0, 4'b0000);
      stop(1);
      rn(1, 0, 0, 0, 4'b1101); rn(1, 1, 0, 0, 4'b0101); rn(1, 2, 0, 0, 4'b0100);
      rn(1, 3, 0, 0, 4'b0000); rn(1, 2, 1, 0, 4'b0100); rn(1, 1, 1, 0, 4'b0101);
      rn(1, 0, 1, 0, 4'b1101);
      rn(1, 1, 0, 1, 4'b0101); rn(1, 2, 0, 0, 4'b0100); rn(1, 3, 0, 0, 4'b0000);
      rn(1, 2, 1, 0, 4'b0100); rn(1, 1, 1, 0, 4'b0101); rn(1, 0, 1, 0, 4'b1101);
      rn(1, 1, 0, 1, 4'b0101);
      stop(1);

      // Shadow timing, edge P=9, cmp0=3: mid-period write lands at the boundary,
      // terminal-cycle write lands one period later.
      cm = pk(3, 0, 0, 0);
      row(0, 0, 1, 9, 1, cm, 0, 0, 0, 4'b0000);
      stop(0);
      rn(0, 0, 0, 0, 4'b0001);
      for (int c = 1; c <= 5; c++) rn(0, c, 0, 0, (c < 3) ? 4'b0001 : 4'b0000);
      row(1, 0, 1, 4, 0, 64'h0, 6, 0, 0, 4'b0000);   // write P=4 while count==5
      for (int c = 7; c <= 9; c++) rn(0, c, 0, 0, 4'b0000);
      rn(0, 0, 0, 1, 4'b0001);
      row(1, 0, 1, 9, 0, 64'h0, 1, 0, 0, 4'b0001);   // rewrite P=9 early in a P=4 period
      rn(0, 2, 0, 0, 4'b0001); rn(0, 3, 0, 0, 4'b0000); rn(0, 4, 0, 0, 4'b0000);
      rn(0, 0, 0, 1, 4'b0001);
      for (int c = 1; c <= 9; c++) rn(0, c, 0, 0, (c < 3) ? 4'b0001 : 4'b0000);
      row(1, 0, 1, 4, 0, 64'h0, 0, 0, 1, 4'b0001);   // write P=4 while count==9 (terminal)
      for (int c = 1; c <= 9; c++) rn(0, c, 0, 0, (c < 3) ? 4'b0001 : 4'b0000);
      rn(0, 0, 0, 1, 4'b0001);
      for (int c = 1; c <= 4; c++) rn(0, c, 0, 0, (c < 3) ? 4'b0001 : 4'b0000);
      rn(0, 0, 0, 1, 4'b0001);
      stop(0);

      // Mode switch at count==2 with P=5: edge period completes, center starts at the boundary.
      row(0, 0, 1, 5, 0, 64'h0, 0, 0, 0, 4'b0000);
      stop(0);
      rn(0, 0, 0, 0, 4'b0001); rn(0, 1, 0, 0, 4'b0001); rn(0, 2, 0, 0, 4'b0001);
      rn(1, 3, 0, 0, 4'b0000); rn(1, 4, 0, 0, 4'b0000); rn(1, 5, 0, 0, 4'b0000);
      rn(1, 1, 0, 1, 4'b0001); rn(1, 2, 0, 0, 4'b0001); rn(1, 3, 0, 0, 4'b0000);
      rn(1, 4, 0, 0, 4'b0000); rn(1, 5, 0, 0, 4'b0000); rn(1, 4, 1, 0, 4'b0000);
      rn(1, 3, 1, 0, 4'b0000); rn(1, 2, 1, 0, 4'b0001); rn(1, 1, 1, 0, 4'b0001);
      rn(1, 0, 1, 0, 4'b0001); rn(1, 1, 0, 1, 4'b0001);
      stop(1);

      // P=0 while enabled holds everything low; writing P=2 starts counting.
      row(0, 0, 1, 0, 0, 64'h0, 0, 0, 0, 4'b0000);
      stop(0);
      rn(0, 0, 0, 0, 4'b0000); rn(0, 0, 0, 0, 4'b0000); rn(0, 0, 0, 0, 4'b0000);
      row(1, 0, 1, 2, 0, 64'h0, 0, 0, 0, 4'b0000);
      rn(0, 0, 0, 0, 4'b0001); rn(0, 1, 0, 0, 4'b0001); rn(0, 2, 0, 0, 4'b0001);
      rn(0, 0, 0, 1, 4'b0001); rn(0, 1, 0, 0, 4'b0001);
      // Compare written mid-period only takes effect at the next period.
      row(1, 0, 0, 0, 1, pk(1, 0, 0, 0), 2, 0, 0, 4'b0001);
      rn(0, 0, 0, 1, 4'b0001); rn(0, 1, 0, 0, 4'b0000); rn(0, 2, 0, 0, 4'b0000);
      rn(0, 0, 0, 1, 4'b0001);
      stop(0);

      // Reset state.
      #22;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_state", {count, dir, update, pwm_out}, 64'h0);

      foreach (vecs[n]) begin
         vec_t exp_v;
         enable    = vecs[n].en;
         mode_in   = vecs[n].mode;
         period_wr = vecs[n].pwr;
         period_in = vecs[n].per;
         cmp_wr    = vecs[n].cwr;
         cmp_in    = vecs[n].cmp;
         sb.push_back(vecs[n]);
         @(posedge clk);
         @(negedge clk);
         exp_v = sb.pop_front();
         check($sformatf("vec%0d cnt/dir/upd/pwm", n), {count, dir, update, pwm_out},
               {exp_v.e_cnt, exp_v.e_dir, exp_v.e_upd, exp_v.e_pwm});
      end
      period_wr = 1'b0;
      cmp_wr    = 1'b0;

      // Mid-period reset: outputs clear at once, and cleared shadows keep the counter idle after release.
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_reset_running", 64'(count != '0), 64'h1);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", {count, dir, update, pwm_out}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("post_reset_idle%0d", k), {count, dir, update, pwm_out}, 64'h0);
      end

`ifdef PWM_PRESCALE_EN
      // prescale=2, P=2: each count held 3 clks, update one clk wide every 9 clks.
      enable    = 1'b0;
      prescale  = 8'd2;
      period_in = 16'd2;
      period_wr = 1'b1;
      cmp_in    = pk(1, 0, 0, 0);
      cmp_wr    = 1'b1;
      @(negedge clk);
      period_wr = 1'b0;
      cmp_wr    = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      for (int k = 0; k < 20; k++) begin
         int ec;
         @(negedge clk);
         ec = (k / 3) % 3;
         check($sformatf("psc%0d cnt/upd/pwm", k), {count, update, pwm_out},
               {16'(ec), ((k > 0) && (k % 9 == 0)), 3'b000, (ec == 0)});
      end
      enable = 1'b0;
      @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
